// File: rtl/dup_txctrl.sv
// DUP11 transmit sequencer: TXDBUF holding register, LSB-first shifter,
// CRC-16 generation/append, abort flag sequence and underrun detection.
module dup_txctrl #(
  parameter logic [15:0] CRCPOLY = 16'hA001,
  parameter logic [15:0] CRCINIT = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dupINIT,
  input  logic       dupSEND,
  input  logic       txCLKEN,
  input  logic       txdbufWRITE,
  input  logic       devLOBYTE,
  input  logic [7:0] dupTXDAT,
  input  logic       dupTXSOM,
  input  logic       dupTXEOM,
  input  logic       dupTXABRT,
  output logic       dupTXD,
  output logic       dupTXDONE,
  output logic       dupTXACT,
  output logic       dupTXCRC,
  output logic       dupTXDLATE
);

  typedef enum logic [1:0] {IDLE, DATA, CRC, ABORT} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [15:0] sh, sh_n;
  logic [15:0] crc, crc_n;
  logic        txd, txd_n;
  logic        full, full_n;
  logic [7:0]  dat;
  logic        som, eom, abrt;
  logic        inmsg, inmsg_n;
  logic        dlate, dlate_n;

  logic        load, avail, take;
  logic [4:0]  last;
  logic [15:0] base_crc;
  logic        base_msg;

  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic b);
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? CRCPOLY : 16'h0000);
  endfunction

  // A load in the same cycle hides the buffer from the shifter.
  assign load  = txdbufWRITE & devLOBYTE;
  assign avail = full & ~load;
  assign last  = (state == CRC) ? 5'd16 : 5'd8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      sh    <= 16'h0000;
      crc   <= CRCINIT;
      txd   <= 1'b1;
      full  <= 1'b0;
      inmsg <= 1'b0;
      dlate <= 1'b0;
    end else if (dupINIT) begin
      state <= IDLE;
      cnt   <= 5'd0;
      sh    <= 16'h0000;
      crc   <= CRCINIT;
      txd   <= 1'b1;
      full  <= 1'b0;
      inmsg <= 1'b0;
      dlate <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      crc   <= crc_n;
      txd   <= txd_n;
      full  <= full_n;
      inmsg <= inmsg_n;
      dlate <= dlate_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat  <= 8'h00;
      som  <= 1'b0;
      eom  <= 1'b0;
      abrt <= 1'b0;
    end else if (load && !dupINIT) begin
      dat  <= dupTXDAT;
      som  <= dupTXSOM;
      eom  <= dupTXEOM;
      abrt <= dupTXABRT;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    crc_n    = crc;
    txd_n    = txd;
    full_n   = full;
    inmsg_n  = inmsg;
    dlate_n  = dlate;
    take     = 1'b0;
    base_crc = crc;
    base_msg = inmsg;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (txCLKEN && dupSEND && avail)
          take = 1'b1;
      end
      default: begin
        if (txCLKEN) begin
          if (cnt == last) begin
            // CRC and abort sequences close the message.
            if (state != DATA) begin
              base_crc = CRCINIT;
              base_msg = 1'b0;
            end
            crc_n   = base_crc;
            inmsg_n = base_msg;
            if (dupSEND && avail) begin
              take = 1'b1;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
              cnt_n   = 5'd0;
              if (base_msg && !avail)
                dlate_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 5'd1;
            sh_n  = sh >> 1;
            txd_n = (state == ABORT) ? 1'b1 : sh[1];
            if (state == DATA)
              crc_n = crc_step(crc, sh[1]);
          end
        end
      end
    endcase

    if (take) begin
      full_n = 1'b0;
      cnt_n  = 5'd1;
      if (abrt) begin
        state_n = ABORT;
        txd_n   = 1'b1;
        crc_n   = CRCINIT;
      end else if (eom) begin
        state_n = CRC;
        sh_n    = base_crc;
        txd_n   = base_crc[0];
        crc_n   = base_crc;
      end else begin
        state_n = DATA;
        sh_n    = {8'h00, dat};
        txd_n   = dat[0];
        crc_n   = crc_step(som ? CRCINIT : base_crc, dat[0]);
        if (som)
          inmsg_n = 1'b1;
      end
    end

    if (load)
      full_n = 1'b1;
  end

  assign dupTXD     = txd;
  assign dupTXDONE  = ~full;
  assign dupTXACT   = (state != IDLE);
  assign dupTXCRC   = crc[0];
  assign dupTXDLATE = dlate;

endmodule

// File: tb/tb_dup_txctrl.sv
// Bench for dup_txctrl: captured serial stream compared against
// expected bit queues built from byte/CRC/abort rules.
module tb_dup_txctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dupINIT = 1'b0;
  logic       dupSEND = 1'b0;
  logic       txCLKEN = 1'b0;
  logic       txdbufWRITE = 1'b0;
  logic       devLOBYTE = 1'b0;
  logic [7:0] dupTXDAT = 8'h00;
  logic       dupTXSOM = 1'b0;
  logic       dupTXEOM = 1'b0;
  logic       dupTXABRT = 1'b0;
  logic       dupTXD, dupTXDONE, dupTXACT, dupTXCRC, dupTXDLATE;

  int n_chk = 0;
  int n_fail = 0;
  int ken_div = 4;
  logic ken_en = 1'b0;
  logic cap[$];
  logic expq[$];
  logic [7:0] msg[$];

  typedef struct {
    logic [7:0] dat;
    logic [7:0] seq;
  } vec_t;
  vec_t tbl[6];

  dup_txctrl dut (
    .clk(clk), .rst(rst), .dupINIT(dupINIT), .dupSEND(dupSEND),
    .txCLKEN(txCLKEN), .txdbufWRITE(txdbufWRITE),
    .devLOBYTE(devLOBYTE), .dupTXDAT(dupTXDAT),
    .dupTXSOM(dupTXSOM), .dupTXEOM(dupTXEOM),
    .dupTXABRT(dupTXABRT), .dupTXD(dupTXD),
    .dupTXDONE(dupTXDONE), .dupTXACT(dupTXACT),
    .dupTXCRC(dupTXCRC), .dupTXDLATE(dupTXDLATE)
  );

  always #5 clk = ~clk;

  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (ken_en && k >= ken_div - 1) begin
        txCLKEN = 1'b1;
        k = 0;
      end else begin
        txCLKEN = 1'b0;
        if (ken_en) k++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (txCLKEN === 1'b1) begin
        #1;
        if (dupTXACT === 1'b1) cap.push_back(dupTXD);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_stream(input string nm);
    int bad;
    bad = -1;
    if (cap.size() != expq.size()) bad = -2;
    else
      for (int i = 0; i < cap.size(); i++)
        if (bad == -1 && cap[i] !== expq[i]) bad = i;
    n_chk++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL %s: got %0d bits expected %0d bits, first bad idx %0d",
               nm, cap.size(), expq.size(), bad);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic wait_act(input logic v, input string nm);
    int k;
    for (k = 0; k < 4000 && dupTXACT !== v; k++) @(negedge clk);
    if (dupTXACT !== v) timeout(nm);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 4000 && dupTXDONE !== 1'b1; k++) @(negedge clk);
    if (dupTXDONE !== 1'b1) timeout(nm);
  endtask

  task automatic wait_bits(input int n, input string nm);
    int k;
    for (k = 0; k < 4000 && cap.size() < n; k++) @(negedge clk);
    if (cap.size() < n) timeout(nm);
  endtask

  task automatic wr(input logic [7:0] d, input logic s,
                    input logic e, input logic a);
    @(negedge clk);
    dupTXDAT = d;
    dupTXSOM = s;
    dupTXEOM = e;
    dupTXABRT = a;
    txdbufWRITE = 1'b1;
    devLOBYTE = 1'b1;
    @(negedge clk);
    txdbufWRITE = 1'b0;
    devLOBYTE = 1'b0;
    dupTXSOM = 1'b0;
    dupTXEOM = 1'b0;
    dupTXABRT = 1'b0;
  endtask

  task automatic init_pulse();
    @(negedge clk);
    dupINIT = 1'b1;
    @(negedge clk);
    dupINIT = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) expq.push_back(b[i]);
  endtask

  task automatic push_crc(input logic [15:0] c);
    for (int i = 0; i < 16; i++) expq.push_back(c[i]);
  endtask

  task automatic push_ones();
    for (int i = 0; i < 8; i++) expq.push_back(1'b1);
  endtask

  function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
    logic [15:0] c;
    logic [7:0] b;
    c = 16'h0000;
    foreach (q[i]) begin
      b = q[i];
      for (int j = 0; j < 8; j++)
        c = (c >> 1) ^ ((c[0] ^ b[j]) ? 16'hA001 : 16'h0000);
    end
    return c;
  endfunction

  initial begin
    logic [7:0] d;
    int nb;
    logic ab;

    // send order: seq[7] goes out first
    tbl[0] = '{dat: 8'hA5, seq: 8'b10100101};
    tbl[1] = '{dat: 8'h01, seq: 8'b10000000};
    tbl[2] = '{dat: 8'h80, seq: 8'b00000001};
    tbl[3] = '{dat: 8'h3C, seq: 8'b00111100};
    tbl[4] = '{dat: 8'hF0, seq: 8'b00001111};
    tbl[5] = '{dat: 8'h96, seq: 8'b01101001};

    repeat (3) @(negedge clk);
    chk("rst_txd", dupTXD, 1);
    chk("rst_done", dupTXDONE, 1);
    chk("rst_act", dupTXACT, 0);
    chk("rst_crc", dupTXCRC, 0);
    chk("rst_dlate", dupTXDLATE, 0);
    rst = 1'b0;
    dupSEND = 1'b1;
    ken_en = 1'b1;
    ken_div = 4;

    // single SOM byte, then underrun
    cap.delete(); expq.delete();
    wr(8'hA5, 1, 0, 0);
    chk("t1_done_low", dupTXDONE, 0);
    wait_act(1, "t1_start");
    chk("t1_done_high", dupTXDONE, 1);
    wait_act(0, "t1_end");
    push_byte(8'hA5);
    chk_stream("t1_stream");
    chk("t1_mark", dupTXD, 1);
    chk("t3_dlate_set", dupTXDLATE, 1);
    init_pulse();
    chk("t3_dlate_clr", dupTXDLATE, 0);

    // table of plain bytes
    foreach (tbl[i]) begin
      cap.delete(); expq.delete();
      wr(tbl[i].dat, 0, 0, 0);
      wait_act(1, "tbl_start");
      wait_act(0, "tbl_end");
      for (int j = 7; j >= 0; j--) expq.push_back(tbl[i].seq[j]);
      chk_stream($sformatf("tbl%0d_stream", i));
      chk($sformatf("tbl%0d_dlate", i), dupTXDLATE, 0);
    end

    // message with CRC
    cap.delete(); expq.delete(); msg.delete();
    wr(8'h01, 1, 0, 0);
    wait_done("t2_b0");
    wr(8'h02, 0, 0, 0);
    wait_done("t2_b1");
    wr(8'h00, 0, 1, 0);
    wait_done("t2_eom");
    wait_act(0, "t2_end");
    msg.push_back(8'h01); msg.push_back(8'h02);
    push_byte(8'h01); push_byte(8'h02);
    push_crc(crc_model(msg));
    chk_stream("t2_stream");
    chk("t2_dlate", dupTXDLATE, 0);

    // abort mid-message
    cap.delete(); expq.delete();
    wr(8'h55, 1, 0, 0);
    wait_done("t4_b0");
    wr(8'h00, 0, 0, 1);
    wait_done("t4_abrt");
    wait_act(0, "t4_end");
    push_byte(8'h55); push_ones();
    chk_stream("t4_stream");
    chk("t4_crc", dupTXCRC, 0);
    chk("t4_dlate", dupTXDLATE, 0);
    wr(8'h5A, 0, 0, 0);
    wait_act(1, "t4_post_start");
    wait_act(0, "t4_post_end");
    chk("t4_msg_cleared", dupTXDLATE, 0);

    // overwrite while full
    cap.delete(); expq.delete();
    dupSEND = 1'b0;
    wr(8'h11, 0, 0, 0);
    wr(8'h22, 0, 0, 0);
    dupSEND = 1'b1;
    wait_act(1, "t5_start");
    wait_act(0, "t5_end");
    push_byte(8'h22);
    chk_stream("t5_stream");

    // async reset mid-byte
    cap.delete();
    wr(8'h00, 0, 0, 0);
    wait_bits(3, "t6_bits");
    wr(8'h77, 0, 0, 0);
    chk("t6_txd_pre", dupTXD, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_txd", dupTXD, 1);
    chk("t6_rst_act", dupTXACT, 0);
    chk("t6_rst_done", dupTXDONE, 1);
    @(negedge clk);
    rst = 1'b0;

    // send dropped mid-byte
    cap.delete(); expq.delete();
    wr(8'h0F, 0, 0, 0);
    wait_bits(2, "t6b_bits");
    wr(8'hC3, 0, 0, 0);
    dupSEND = 1'b0;
    wait_act(0, "t6b_end");
    push_byte(8'h0F);
    chk_stream("t6b_stream");
    repeat (4 * ken_div) @(negedge clk);
    chk("t6b_idle", dupTXACT, 0);
    chk("t6b_retained", dupTXDONE, 0);
    cap.delete(); expq.delete();
    dupSEND = 1'b1;
    wait_act(1, "t6c_start");
    wait_act(0, "t6c_end");
    push_byte(8'hC3);
    chk_stream("t6c_stream");
    chk("t6c_dlate", dupTXDLATE, 0);

    // randomized back-to-back messages
    for (int r = 0; r < 3; r++) begin
      init_pulse();
      ken_div = $urandom_range(2, 6);
      cap.delete(); expq.delete();
      for (int m = 0; m < 4; m++) begin
        msg.delete();
        nb = $urandom_range(1, 3);
        ab = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < nb; i++) begin
          d = 8'($urandom);
          wr(d, i == 0, 0, 0);
          msg.push_back(d);
          push_byte(d);
          wait_done("rnd_byte");
        end
        if (ab) begin
          wr(8'h00, 0, 0, 1);
          push_ones();
        end else begin
          wr(8'h00, 0, 1, 0);
          push_crc(crc_model(msg));
        end
        wait_done("rnd_term");
      end
      wait_act(0, "rnd_end");
      chk_stream($sformatf("rnd%0d_stream", r));
      chk($sformatf("rnd%0d_dlate", r), dupTXDLATE, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
